// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//
// Shares one single-cycle combinational ALU between two requesters using
// round-robin arbitration.
//   - Port 0 is the execute stage.
//   - Port 1 is the address/branch-compare helper.
// The granted request drives the ALU function select and operands. The ALU
// result is captured into a one-entry registered response buffer, together
// with the issuing port id and the requester's tag.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   req{0,1}_valid/ready  request handshake per port
//   req{0,1}_f/a/b/tag    request payload (one-hot op, operands, tag)
//   alu_f/a/b             drive to the shared ALU (all zero when idle)
//   alu_y                 combinational ALU result
//   rsp_valid/ready       response handshake
//   rsp_id/tag/y          issuing port, its tag and the captured result

module alu_share_arbiter #(
    parameter int unsigned DW    = 32,
    parameter int unsigned FW    = 12,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [FW-1:0]    req0_f,
    input  logic [DW-1:0]    req0_a,
    input  logic [DW-1:0]    req0_b,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [FW-1:0]    req1_f,
    input  logic [DW-1:0]    req1_a,
    input  logic [DW-1:0]    req1_b,
    input  logic [TAG_W-1:0] req1_tag,

    output logic [FW-1:0]    alu_f,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    input  logic [DW-1:0]    alu_y,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [DW-1:0]    rsp_y
);

    // Round-robin pointer: the port that wins when both are valid.
    logic             ptr_q, ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [DW-1:0]    rsp_y_q, rsp_y_d;

    logic can_issue;
    logic grant0, grant1;

    // Grant logic. Reset blocks any grant so a request pending at reset is
    // never accepted. alu_y does not feed any of this.
    always_comb begin
        can_issue = ~rst & (~rsp_valid_q | rsp_ready);
        grant0    = can_issue & req0_valid & (~req1_valid | ~ptr_q);
        grant1    = can_issue & req1_valid & (~req0_valid | ptr_q);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // ALU drive: zero on idle cycles so the ALU produces 0.
    always_comb begin
        alu_f = '0;
        alu_a = '0;
        alu_b = '0;
        if (grant0) begin
            alu_f = req0_f;
            alu_a = req0_a;
            alu_b = req0_b;
        end else if (grant1) begin
            alu_f = req1_f;
            alu_a = req1_a;
            alu_b = req1_b;
        end
    end

    // Next state. A grant always fills the buffer, which also covers the
    // simultaneous drain-and-fill case. A drain without a grant only clears
    // the valid flag; the payload is left as it was.
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_y_d     = rsp_y_q;

        if (grant0 || grant1) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant1;
            rsp_tag_d   = grant1 ? req1_tag : req0_tag;
            rsp_y_d     = alu_y;
            ptr_d       = grant0;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_y_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_y_q     <= rsp_y_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_y     = rsp_y_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//
// Directed bench for alu_share_arbiter. A small combinational ALU model
// drives alu_y. Per-cycle vectors give the request and rsp_ready stimulus.
// Each vector also gives the expected readies, alu_f and response outputs for
// that cycle, sampled one time unit after the falling edge.

module tb_alu_share_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned FW    = 12;
    localparam int unsigned TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready;
    logic [FW-1:0]    req0_f;
    logic [DW-1:0]    req0_a, req0_b;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid, req1_ready;
    logic [FW-1:0]    req1_f;
    logic [DW-1:0]    req1_a, req1_b;
    logic [TAG_W-1:0] req1_tag;
    logic [FW-1:0]    alu_f;
    logic [DW-1:0]    alu_a, alu_b, alu_y;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [DW-1:0]    rsp_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DW(DW), .FW(FW), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_f     (req0_f),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_f     (req1_f),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_tag   (req1_tag),
        .alu_f      (alu_f),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_y      (alu_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag),
        .rsp_y      (rsp_y)
    );

    // One-hot ALU; anything that is not exactly one known bit yields 0.
    function automatic logic [DW-1:0] alu_model(input logic [FW-1:0] f,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        case (f)
            12'h001: return a + b;
            12'h002: return a - b;
            12'h004: return {31'd0, a < b};
            12'h008: return {31'd0, $signed(a) < $signed(b)};
            12'h010: return a & b;
            12'h020: return a | b;
            12'h040: return a ^ b;
            12'h080: return a << b[4:0];
            12'h100: return a >> b[4:0];
            12'h200: return $unsigned($signed(a) >>> b[4:0]);
            12'h400: return a;
            12'h800: return b;
            default: return '0;
        endcase
    endfunction

    always_comb alu_y = alu_model(alu_f, alu_a, alu_b);

    typedef struct {
        logic             v;
        logic [FW-1:0]    f;
        logic [DW-1:0]    a;
        logic [DW-1:0]    b;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef struct {
        logic             r0;
        logic             r1;
        logic             v;
        logic             id;
        logic [TAG_W-1:0] tag;
        logic [DW-1:0]    y;
        logic [FW-1:0]    f;
    } exp_t;

    typedef struct {
        req_t p0;
        req_t p1;
        logic rr;
        exp_t e;
    } vec_t;

    vec_t tbl[$];

    function automatic req_t rq(input logic v, input logic [FW-1:0] f,
                                input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [TAG_W-1:0] tag);
        req_t r;
        r.v = v; r.f = f; r.a = a; r.b = b; r.tag = tag;
        return r;
    endfunction

    function automatic exp_t ex(input logic r0, input logic r1, input logic v,
                                input logic id, input logic [TAG_W-1:0] tag,
                                input logic [DW-1:0] y, input logic [FW-1:0] f);
        exp_t e;
        e.r0 = r0; e.r1 = r1; e.v = v; e.id = id; e.tag = tag; e.y = y; e.f = f;
        return e;
    endfunction

    task automatic add(input req_t p0, input req_t p1, input logic rr, input exp_t e);
        vec_t t;
        t.p0 = p0; t.p1 = p1; t.rr = rr; t.e = e;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input req_t p0, input req_t p1, input logic rr);
        req0_valid = p0.v; req0_f = p0.f; req0_a = p0.a; req0_b = p0.b; req0_tag = p0.tag;
        req1_valid = p1.v; req1_f = p1.f; req1_a = p1.a; req1_b = p1.b; req1_tag = p1.tag;
        rsp_ready  = rr;
    endtask

    req_t idle;
    req_t s0, s1, s2, s3, s4, s5, s6, s7, s8, s9;

    initial begin
        idle = rq(0, 12'h000, 0, 0, 0);
        // Payloads shared by consecutive cycles while a requester waits for ready.
        s0 = rq(1, 12'h001, 10, 20, 4'h1);                     // add -> 30
        s1 = rq(1, 12'h002, 100, 1, 4'h9);                     // sub -> 99
        s2 = rq(1, 12'h010, 32'hF0F0, 32'hFF00, 4'h3);         // and -> F000
        s3 = rq(1, 12'h020, 32'h0F, 32'hF0, 4'hA);             // or  -> FF
        s4 = rq(1, 12'h040, 32'hFF, 32'h0F, 4'h4);             // xor -> F0
        s5 = rq(1, 12'h080, 1, 4, 4'hB);                       // sll -> 10
        s6 = rq(1, 12'h100, 32'h80, 3, 4'h6);                  // srl -> 10
        s7 = rq(1, 12'h200, 32'h8000_0000, 4, 4'hC);           // sra -> F8000000
        s8 = rq(1, 12'h008, 32'hFFFF_FFFF, 1, 4'h7);           // slt -> 1
        s9 = rq(1, 12'h004, 32'hFFFF_FFFF, 1, 4'h8);           // sltu -> 0

        // Columns: port0, port1, rsp_ready,
        //          ex(ready0, ready1, rsp_valid, rsp_id, rsp_tag, rsp_y, alu_f)
        add(idle, idle, 1, ex(0, 0, 0, 0, 4'h0, 32'h0, 12'h000));
        // Single request, response next cycle.
        add(rq(1, 12'h001, 5, 3, 4'h2), idle, 1, ex(1, 0, 0, 0, 4'h0, 32'h0, 12'h001));
        add(idle, idle, 1, ex(0, 0, 1, 0, 4'h2, 32'd8, 12'h000));
        // Drained buffer keeps its payload; port1 alone moves the pointer to 0.
        add(idle, rq(1, 12'h004, 3, 7, 4'h5), 1, ex(0, 1, 0, 0, 4'h2, 32'd8, 12'h004));
        // Both valid: alternation 0,1,0,1,0,1.
        add(s0, s1, 1, ex(1, 0, 1, 1, 4'h5, 32'd1, 12'h001));
        add(s2, s1, 1, ex(0, 1, 1, 0, 4'h1, 32'd30, 12'h002));
        add(s2, s3, 1, ex(1, 0, 1, 1, 4'h9, 32'd99, 12'h010));
        add(s4, s3, 1, ex(0, 1, 1, 0, 4'h3, 32'hF000, 12'h020));
        add(s4, s5, 1, ex(1, 0, 1, 1, 4'hA, 32'hFF, 12'h040));
        add(s6, s5, 1, ex(0, 1, 1, 0, 4'h4, 32'hF0, 12'h080));
        // Backpressure for four cycles, then drain plus grant together.
        for (int i = 0; i < 4; i++)
            add(s6, s7, 0, ex(0, 0, 1, 1, 4'hB, 32'h10, 12'h000));
        add(s6, s7, 1, ex(1, 0, 1, 1, 4'hB, 32'h10, 12'h100));
        add(idle, s7, 1, ex(0, 1, 1, 0, 4'h6, 32'h10, 12'h200));
        // Signed versus unsigned compare on port 1.
        add(idle, s8, 1, ex(0, 1, 1, 1, 4'hC, 32'hF800_0000, 12'h008));
        add(idle, s9, 1, ex(0, 1, 1, 1, 4'h7, 32'd1, 12'h004));
        // Non-one-hot op passes through and returns 0 with its tag.
        add(rq(1, 12'h003, 5, 3, 4'hD), idle, 1, ex(1, 0, 1, 1, 4'h8, 32'd0, 12'h003));
        add(idle, idle, 0, ex(0, 0, 1, 0, 4'hD, 32'd0, 12'h000));
        add(idle, idle, 1, ex(0, 0, 1, 0, 4'hD, 32'd0, 12'h000));
        add(idle, idle, 1, ex(0, 0, 0, 0, 4'hD, 32'd0, 12'h000));

        rst = 1'b1;
        drive(idle, idle, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].p0, tbl[i].p1, tbl[i].rr);
            #1;
            check($sformatf("v%0d req0_ready", i), 32'(req0_ready), 32'(tbl[i].e.r0));
            check($sformatf("v%0d req1_ready", i), 32'(req1_ready), 32'(tbl[i].e.r1));
            check($sformatf("v%0d alu_f", i), 32'(alu_f), 32'(tbl[i].e.f));
            check($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e.v));
            check($sformatf("v%0d rsp_id", i), 32'(rsp_id), 32'(tbl[i].e.id));
            check($sformatf("v%0d rsp_tag", i), 32'(rsp_tag), 32'(tbl[i].e.tag));
            check($sformatf("v%0d rsp_y", i), rsp_y, tbl[i].e.y);
        end

        // Reset while a response is buffered and both ports are requesting.
        // The pointer is left at port 1 so the post-reset grant proves it reset.
        @(negedge clk);
        drive(rq(1, 12'h001, 1, 1, 4'h1), idle, 1'b1);
        #1;
        check("rst_pre req0_ready", 32'(req0_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        drive(rq(1, 12'h001, 2, 2, 4'h2), rq(1, 12'h001, 7, 7, 4'h3), 1'b1);
        #1;
        check("rst_in rsp_valid", 32'(rsp_valid), 32'd1);
        check("rst_in req0_ready", 32'(req0_ready), 32'd0);
        check("rst_in req1_ready", 32'(req1_ready), 32'd0);
        check("rst_in alu_f", 32'(alu_f), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_post rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_post rsp_tag", 32'(rsp_tag), 32'd0);
        check("rst_post rsp_y", rsp_y, 32'd0);
        check("rst_post req0_ready", 32'(req0_ready), 32'd1);
        check("rst_post req1_ready", 32'(req1_ready), 32'd0);
        @(negedge clk);
        drive(idle, idle, 1'b1);
        #1;
        check("rst_rsp rsp_valid", 32'(rsp_valid), 32'd1);
        check("rst_rsp rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp rsp_tag", 32'(rsp_tag), 32'd2);
        check("rst_rsp rsp_y", rsp_y, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
